// File: rtl/cfg_reg_bank_pkg.sv
// cfg_reg_pkg: shared constants for the configuration/status register bank.
// Holds the default reset image for the 8x16 map, the register index enum
// of that default map, and the index of the register that carries the LOCK
// bit when lock support is built in.
package cfg_reg_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;

  typedef enum logic [2:0] {
    ADC0_REG         = 3'd0,
    ADC1_REG         = 3'd1,
    TEMP_SENSOR0_REG = 3'd2,
    TEMP_SENSOR1_REG = 3'd3,
    ANALOG_TEST      = 3'd4,
    DIGITAL_TEST     = 3'd5,
    AMP_GAIN         = 3'd6,
    DIGITAL_CONFIG   = 3'd7
  } reg_t;

  // The lock bit lives in the top bit of the last register.
  localparam reg_t LOCK_REG = DIGITAL_CONFIG;

  // Register i occupies bits [i*16 +: 16].
  localparam logic [DEF_NUM_REGS*DEF_DATA_W-1:0] DEF_RESET_VALS = {
    16'h0001,  // DIGITAL_CONFIG
    16'h0000,  // AMP_GAIN
    16'h0000,  // DIGITAL_TEST
    16'hABCD,  // ANALOG_TEST
    16'h0000,  // TEMP_SENSOR1_REG
    16'h0000,  // TEMP_SENSOR0_REG
    16'h0000,  // ADC1_REG
    16'hFFFF   // ADC0_REG
  };

  // Extracts word idx from a packed default-sized register image.
  function automatic logic [DEF_DATA_W-1:0] def_word(
    input logic [DEF_NUM_REGS*DEF_DATA_W-1:0] flat,
    input reg_t                               idx
  );
    return flat[int'(idx)*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/cfg_reg_word.sv
// cfg_reg_word: one register of the bank with per-bit attributes.
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset, loads RESET_VAL
//   wr_en    - host write to this register (already address/lock qualified)
//   data_in  - host write data
//   hw_set   - per-bit hardware set pulses, effective on W1C bits only
//   q        - live register value
// Bit kinds: W1C (W1C_MASK), read-only (RO_MASK and not W1C), normal.
module cfg_reg_word #(
  parameter int unsigned        DATA_W    = 16,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter logic [DATA_W-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]  W1C_MASK  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] hw_set,
  output logic [DATA_W-1:0] q
);

  // W1C takes precedence when a bit is flagged in both masks.
  localparam logic [DATA_W-1:0] W1C_BITS  = W1C_MASK;
  localparam logic [DATA_W-1:0] RO_BITS   = RO_MASK & ~W1C_MASK;
  localparam logic [DATA_W-1:0] NORM_BITS = ~(RO_MASK | W1C_MASK);

  logic [DATA_W-1:0] q_next;

  always_comb begin
    q_next = q;
    if (wr_en) begin
      q_next = (q & RO_BITS)
             | (data_in & NORM_BITS)
             | (q & ~data_in & W1C_BITS);
    end
    // Hardware set is applied last so it wins over a same-cycle clear.
    q_next = q_next | (hw_set & W1C_BITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: parametrised configuration/status register bank.
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   write     - write strobe
//   read      - read strobe
//   address   - register index for read/write
//   data_in   - write data
//   hw_set    - per-bit hardware set pulses (W1C bits only)
//   data_out  - registered read data, held until the next read
//   rd_valid  - one-cycle pulse, data_out updated
//   err       - one-cycle pulse, access rejected (out of range or locked)
//   regs_flat - live contents of all registers, register i at slice i
// Optional feature macro: CFG_REG_LOCK_EN (top bit of the last register
// becomes a sticky write lock, cleared only by reset).
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int unsigned                    DATA_W     = 16,
  parameter int unsigned                    NUM_REGS   = 8,
  parameter int unsigned                    ADDR_W     = $clog2(NUM_REGS),
  parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VALS = DEF_RESET_VALS,
  parameter logic [NUM_REGS*DATA_W-1:0]     RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]     W1C_MASK   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  logic                in_range;
  logic                wr_blocked;
  logic                wr_ok;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   rd_mux;

  // Out-of-range addresses only exist when NUM_REGS is not a power of two.
  if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (address < ADDR_W'(NUM_REGS));
  end

`ifdef CFG_REG_LOCK_EN
  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(NUM_REGS - 1);

  logic locked;

  // The write that sets the lock is itself accepted; later writes are not.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked <= 1'b0;
    end else if (write && in_range && !locked &&
                 (address == LOCK_ADDR) && data_in[DATA_W-1]) begin
      locked <= 1'b1;
    end
  end

  assign wr_blocked = locked;
`else
  assign wr_blocked = 1'b0;
`endif

  assign wr_ok = write & in_range & ~wr_blocked;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    assign wr_en[i] = wr_ok & (address == ADDR_W'(i));

    cfg_reg_word #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VALS[i*DATA_W +: DATA_W]),
      .RO_MASK   (RO_MASK[i*DATA_W +: DATA_W]),
      .W1C_MASK  (W1C_MASK[i*DATA_W +: DATA_W])
    ) u_word (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .data_in (data_in),
      .hw_set  (hw_set[i*DATA_W +: DATA_W]),
      .q       (regs_flat[i*DATA_W +: DATA_W])
    );
  end

  // Reads the pre-edge register value, so a same-cycle write is not seen.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) begin
        rd_mux = regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= read;
      if (read) begin
        data_out <= rd_mux;
      end
      err <= (~in_range & (read | write)) | (write & in_range & wr_blocked);
    end
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
module tb_cfg_reg_bank;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [2:0]   address = '0;
  logic [15:0]  data_in = '0;
  logic [127:0] hw_set = '0;

  logic [15:0]  dout0, dout1, dout2;
  logic         v0, v1, v2, e0, e1, e2;
  logic [127:0] flat0, flat1;
  logic [95:0]  flat2;

  always #5 clk = ~clk;

  localparam logic [127:0] EXP_DEF = {16'h0001, 16'h0000, 16'h0000, 16'hABCD,
                                      16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
  localparam logic [127:0] RO1  = {96'h0, 16'h00FF, 16'h0000};
  localparam logic [127:0] W1C1 = {80'h0, 16'h000F, 16'h0000, 16'h0000};
  localparam logic [95:0]  RESET2 = {16'h6666, 16'h5555, 16'h4444,
                                     16'h3333, 16'h2222, 16'h1111};

  cfg_reg_bank dut0 (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .data_in(data_in), .hw_set(hw_set), .data_out(dout0), .rd_valid(v0),
    .err(e0), .regs_flat(flat0)
  );

  cfg_reg_bank #(.RO_MASK(RO1), .W1C_MASK(W1C1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .data_in(data_in), .hw_set(hw_set), .data_out(dout1), .rd_valid(v1),
    .err(e1), .regs_flat(flat1)
  );

  cfg_reg_bank #(.NUM_REGS(6), .RESET_VALS(RESET2)) dut2 (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .data_in(data_in), .hw_set(hw_set[95:0]), .data_out(dout2), .rd_valid(v2),
    .err(e2), .regs_flat(flat2)
  );

  int unsigned sel = 0;
  logic [15:0] dout_s;
  logic        v_s, e_s;

  always_comb begin
    case (sel)
      0:       begin dout_s = dout0; v_s = v0; e_s = e0; end
      1:       begin dout_s = dout1; v_s = v1; e_s = e1; end
      default: begin dout_s = dout2; v_s = v2; e_s = e2; end
    endcase
  end

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; a read pushes its expectation, the response is popped
  // and compared just after the edge that produces it.
  task automatic step(input string tag, input logic wr, input logic rd,
                      input logic [2:0] a, input logic [15:0] d,
                      input logic [127:0] hw, input logic [15:0] exp_d,
                      input logic exp_e);
    exp_t e;
    @(negedge clk);
    write = wr; read = rd; address = a; data_in = d; hw_set = hw;
    if (rd) sb.push_back('{exp_d, exp_e});
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; hw_set = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 128'(v_s), 128'(1'b1));
      chk({tag, "_data"}, 128'(dout_s), 128'(e.data));
      chk({tag, "_err"}, 128'(e_s), 128'(e.err));
    end else begin
      chk({tag, "_novalid"}, 128'(v_s), 128'(1'b0));
      chk({tag, "_err"}, 128'(e_s), 128'(exp_e));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; write = 1'b0; read = 1'b0; hw_set = '0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_flat0", flat0, EXP_DEF);
    chk("rst_flat2", 128'(flat2), 128'(RESET2));
    chk("rst_dout", 128'(dout0), 128'(0));
    chk("rst_valid", 128'({v0, v1, v2}), 128'(0));
    chk("rst_err", 128'({e0, e1, e2}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [127:0] defv;
  logic [15:0]  prior, pat, exp_ro;

  initial begin
    defv = EXP_DEF;

    // Reset defaults, back-to-back reads of every register.
    sel = 0;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      step("def_rd", 1'b0, 1'b1, 3'(r), '0, '0, defv[r*16 +: 16], 1'b0);
    end
    step("idle", 1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    chk("hold", 128'(dout0), 128'(16'h0001));

    // RO reg1 = 00FF, W1C reg2 = 000F on dut1.
    sel = 1;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      step("ro_wr", 1'b1, 1'b0, 3'(r), 16'hFFFF, '0, '0, 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      exp_ro = (r == 1) ? 16'hFF00 : (r == 2) ? 16'hFFF0 : 16'hFFFF;
      step("ro_rd", 1'b0, 1'b1, 3'(r), '0, '0, exp_ro, 1'b0);
    end

    do_reset();
    step("w1c_set", 1'b0, 1'b0, 3'd2, '0, 128'(1) << 35, '0, 1'b0);
    step("w1c_rd1", 1'b0, 1'b1, 3'd2, '0, '0, 16'h0008, 1'b0);
    step("w1c_clr", 1'b1, 1'b0, 3'd2, 16'h0008, '0, '0, 1'b0);
    step("w1c_rd2", 1'b0, 1'b1, 3'd2, '0, '0, 16'h0000, 1'b0);
    step("w1c_both", 1'b1, 1'b0, 3'd2, 16'h0008, 128'(1) << 35, '0, 1'b0);
    step("w1c_rd3", 1'b0, 1'b1, 3'd2, '0, '0, 16'h0008, 1'b0);
    step("hw_norm", 1'b0, 1'b0, 3'd3, '0, 128'(1) << 48, '0, 1'b0);
    step("hw_norm_rd", 1'b0, 1'b1, 3'd3, '0, '0, 16'h0000, 1'b0);

    // Six-register instance: out-of-range accesses.
    sel = 2;
    do_reset();
    step("oor_wr", 1'b1, 1'b0, 3'd6, 16'hBEEF, '0, '0, 1'b1);
    chk("oor_nochg", 128'(flat2), 128'(RESET2));
    step("oor_rd", 1'b0, 1'b1, 3'd7, '0, '0, 16'h0000, 1'b1);
    step("last_rd", 1'b0, 1'b1, 3'd5, '0, '0, 16'h6666, 1'b0);
    step("last_wr", 1'b1, 1'b0, 3'd5, 16'h1234, '0, '0, 1'b0);
    step("last_rd2", 1'b0, 1'b1, 3'd5, '0, '0, 16'h1234, 1'b0);

    // Walking one; the same-cycle read returns the prior pattern.
    sel = 0;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      prior = defv[r*16 +: 16];
      for (int b = 0; b < 16; b++) begin
        pat = 16'(1) << b;
        step("walk_rw", 1'b1, 1'b1, 3'(r), pat, '0, prior, 1'b0);
        step("walk_rd", 1'b0, 1'b1, 3'(r), '0, '0, pat, 1'b0);
        prior = pat;
      end
    end

`ifdef CFG_REG_LOCK_EN
    sel = 0;
    do_reset();
    step("lk_set", 1'b1, 1'b0, 3'd7, 16'h8000, '0, '0, 1'b0);
    step("lk_wr5", 1'b1, 1'b0, 3'd5, 16'h1234, '0, '0, 1'b1);
    step("lk_rd5", 1'b0, 1'b1, 3'd5, '0, '0, 16'h0000, 1'b0);
    step("lk_wr7", 1'b1, 1'b0, 3'd7, 16'h0000, '0, '0, 1'b1);
    step("lk_rd7", 1'b0, 1'b1, 3'd7, '0, '0, 16'h8000, 1'b0);
    do_reset();
    step("lk_post_wr", 1'b1, 1'b0, 3'd5, 16'h1234, '0, '0, 1'b0);
    step("lk_post_rd", 1'b0, 1'b1, 3'd5, '0, '0, 16'h1234, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
